// File: rtl/bp_be_dcache_wbuf_drain_if.sv
// Write-buffer drain bus: wbuf valid/yumi side, data-mem write port, and stall/idle status.
// Handshakes: wbuf entry transfers when wbuf_v_i & wbuf_yumi_o; staged write commits when dmem_v_o & dmem_yumi_i.
interface bp_be_dcache_wbuf_drain_if
  #(parameter int data_width_p  = 64
   ,parameter int paddr_width_p = 56
   ,parameter int ways_p        = 8
   ,parameter int sets_p        = 64
   );

   localparam int way_id_width_lp = $clog2(ways_p);
   localparam int mask_width_lp   = data_width_p / 8;
   localparam int entry_width_lp  = paddr_width_p + way_id_width_lp + data_width_p + mask_width_lp;
   localparam int addr_width_lp   = $clog2(sets_p) + $clog2(ways_p);

   // Entry layout, MSB first: {paddr, way_id, data, mask}
   logic                      wbuf_v_i;
   logic [entry_width_lp-1:0] wbuf_entry_i;
   logic                      wbuf_yumi_o;

   logic                      dmem_v_o;
   logic [ways_p-1:0]         dmem_bank_en_o;
   logic [addr_width_lp-1:0]  dmem_addr_o;
   logic [data_width_p-1:0]   dmem_data_o;
   logic [mask_width_lp-1:0]  dmem_mask_o;
   logic                      dmem_yumi_i;

   logic                      drain_req_i;
   logic                      stall_req_o;
   logic                      idle_o;
   logic                      dbg_state_o;

   modport slave
     (input  wbuf_v_i, wbuf_entry_i, dmem_yumi_i, drain_req_i
     ,output wbuf_yumi_o, dmem_v_o, dmem_bank_en_o, dmem_addr_o, dmem_data_o, dmem_mask_o
     ,output stall_req_o, idle_o, dbg_state_o
     );

   modport master
     (output wbuf_v_i, wbuf_entry_i, dmem_yumi_i, drain_req_i
     ,input  wbuf_yumi_o, dmem_v_o, dmem_bank_en_o, dmem_addr_o, dmem_data_o, dmem_mask_o
     ,input  stall_req_o, idle_o, dbg_state_o
     );

endinterface

// File: rtl/bp_be_dcache_wbuf_drain.sv
// Drain end of the dcache write buffer: stages one entry and commits it to the
// rotated, word-interleaved data SRAM banks, escalating to a stall when starved.
module bp_be_dcache_wbuf_drain
  #(parameter int data_width_p   = 64
   ,parameter int paddr_width_p  = 56
   ,parameter int ways_p         = 8
   ,parameter int sets_p         = 64
   ,parameter int starve_limit_p = 4
   )
  (input logic clk_i
  ,input logic reset_n_i
  ,bp_be_dcache_wbuf_drain_if.slave wbuf_if
  );

   localparam int mask_width_lp    = data_width_p / 8;
   localparam int byte_offset_lp   = $clog2(mask_width_lp);
   localparam int word_offset_w_lp = $clog2(ways_p);
   localparam int block_offset_lp  = byte_offset_lp + word_offset_w_lp;
   localparam int index_w_lp       = $clog2(sets_p);
   localparam int addr_w_lp        = index_w_lp + word_offset_w_lp;
   localparam int entry_w_lp       = paddr_width_p + word_offset_w_lp + data_width_p + mask_width_lp;
   localparam int cnt_w_lp         = $clog2(starve_limit_p + 1);
   localparam logic [cnt_w_lp-1:0] starve_limit_lp = cnt_w_lp'(starve_limit_p);

   typedef enum logic {ST_EMPTY, ST_PENDING} state_e;

   state_e                      state_q, state_d;
   logic [cnt_w_lp-1:0]         cnt_q, cnt_d;
   logic [word_offset_w_lp-1:0] bank_q, bank_d;
   logic [addr_w_lp-1:0]        addr_q, addr_d;
   logic [data_width_p-1:0]     data_q, data_d;
   logic [mask_width_lp-1:0]    mask_q, mask_d;

   logic [entry_w_lp-1:0]       entry;
   logic [paddr_width_p-1:0]    in_paddr;
   logic [word_offset_w_lp-1:0] in_way;
   logic [data_width_p-1:0]     in_data;
   logic [mask_width_lp-1:0]    in_mask;
   logic [index_w_lp-1:0]       in_index;
   logic [word_offset_w_lp-1:0] in_word_off;
   logic [word_offset_w_lp-1:0] in_bank;
   logic                        capture;
   logic                        pending;
   logic                        unused_paddr_bits;

   assign entry       = wbuf_if.wbuf_entry_i;
   assign in_mask     = entry[mask_width_lp-1:0];
   assign in_data     = entry[mask_width_lp+data_width_p-1:mask_width_lp];
   assign in_way      = entry[mask_width_lp+data_width_p+word_offset_w_lp-1:mask_width_lp+data_width_p];
   assign in_paddr    = entry[entry_w_lp-1:entry_w_lp-paddr_width_p];
   assign in_index    = in_paddr[block_offset_lp+index_w_lp-1:block_offset_lp];
   assign in_word_off = in_paddr[block_offset_lp-1:byte_offset_lp];
   // Rotation add wraps on its own because ways_p is a power of two
   assign in_bank     = in_way + in_word_off;

   assign unused_paddr_bits = ^{in_paddr[paddr_width_p-1:block_offset_lp+index_w_lp],
                                in_paddr[byte_offset_lp-1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            cnt_d = '0;
            if (wbuf_if.wbuf_v_i) begin
               capture = 1'b1;
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (wbuf_if.dmem_yumi_i) begin
               cnt_d = '0;
               if (wbuf_if.wbuf_v_i) begin
                  capture = 1'b1;
               end else begin
                  state_d = ST_EMPTY;
               end
            end else if (cnt_q != starve_limit_lp) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      bank_d = bank_q;
      addr_d = addr_q;
      data_d = data_q;
      mask_d = mask_q;
      if (capture) begin
         bank_d = in_bank;
         addr_d = {in_index, in_word_off};
         data_d = in_data;
         mask_d = in_mask;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
         bank_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   assign pending = (state_q == ST_PENDING);

   always_comb begin
      wbuf_if.wbuf_yumi_o = 1'b0;
      if (pending) begin
         wbuf_if.wbuf_yumi_o = wbuf_if.dmem_yumi_i & wbuf_if.wbuf_v_i;
      end else begin
         wbuf_if.wbuf_yumi_o = wbuf_if.wbuf_v_i;
      end
   end

   always_comb begin
      wbuf_if.dmem_bank_en_o = '0;
      if (pending) begin
         wbuf_if.dmem_bank_en_o = ways_p'(1) << bank_q;
      end
   end

   assign wbuf_if.dmem_v_o    = pending;
   assign wbuf_if.dmem_addr_o = addr_q;
   assign wbuf_if.dmem_data_o = data_q;
   assign wbuf_if.dmem_mask_o = mask_q;
   assign wbuf_if.dbg_state_o = pending;

   // A fence only escalates when there is actually something left to drain
   assign wbuf_if.stall_req_o = (pending & (cnt_q == starve_limit_lp))
                              | (wbuf_if.drain_req_i & (pending | wbuf_if.wbuf_v_i));
   assign wbuf_if.idle_o      = ~pending & ~wbuf_if.wbuf_v_i;

endmodule

// File: tb/tb_bp_be_dcache_wbuf_drain.sv
// Bench for bp_be_dcache_wbuf_drain: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_bp_be_dcache_wbuf_drain;
  localparam int DW    = 64;
  localparam int PW    = 56;
  localparam int WAYS  = 8;
  localparam int SETS  = 64;
  localparam int LIMIT = 4;
  localparam int WW    = 3;
  localparam int MW    = 8;
  localparam int EW    = PW + WW + DW + MW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_dcache_wbuf_drain_if #(.data_width_p(DW), .paddr_width_p(PW), .ways_p(WAYS), .sets_p(SETS)) bus();

  bp_be_dcache_wbuf_drain #(
    .data_width_p(DW), .paddr_width_p(PW), .ways_p(WAYS), .sets_p(SETS), .starve_limit_p(LIMIT)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .wbuf_if(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int starve = 0;
  int commits = 0;

  typedef struct {
    int          idx;
    int          off;
    int          way;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [7:0]  exp_bank_en;
    logic [8:0]  exp_addr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk_entry(input int idx, input int off, input int way,
                                             input logic [63:0] data, input logic [7:0] mask);
    logic [PW-1:0] paddr;
    paddr = PW'({$urandom(), $urandom()});
    paddr[11:6] = 6'(idx);
    paddr[5:3]  = 3'(off);
    return {paddr, 3'(way), data, mask};
  endfunction

  // Inputs change 1ns after the edge; outputs are sampled 3ns later.
  task automatic drive(input logic v, input logic [EW-1:0] e, input logic dy, input logic dr);
    @(posedge clk);
    #1;
    bus.wbuf_v_i     = v;
    bus.wbuf_entry_i = e;
    bus.dmem_yumi_i  = dy;
    bus.drain_req_i  = dr;
    #3;
  endtask

  task automatic model_cycle();
    logic          pend;
    logic          v;
    logic          dy;
    logic          dr;
    logic [EW-1:0] e;
    logic [PW-1:0] paddr;
    int            way;
    int            idx;
    int            off;
    int            bank;
    pend = (exp_q.size() != 0);
    v    = bus.wbuf_v_i;
    dy   = bus.dmem_yumi_i;
    dr   = bus.drain_req_i;
    chk("rand_yumi", 64'(bus.wbuf_yumi_o), 64'(pend ? (dy && v) : v));
    chk("rand_dmem_v", 64'(bus.dmem_v_o), 64'(pend));
    if (pend) begin
      e     = exp_q[0];
      paddr = e[EW-1:EW-PW];
      way   = int'(e[MW+DW+WW-1:MW+DW]);
      idx   = int'((paddr >> 6) % 64);
      off   = int'((paddr >> 3) % 8);
      bank  = (way + off) % WAYS;
      chk("rand_bank_en", 64'(bus.dmem_bank_en_o), 64'(1 << bank));
      chk("rand_addr", 64'(bus.dmem_addr_o), 64'(idx * WAYS + off));
      chk("rand_data", bus.dmem_data_o, e[MW+DW-1:MW]);
      chk("rand_mask", 64'(bus.dmem_mask_o), 64'(e[MW-1:0]));
    end else begin
      chk("rand_bank_en_idle", 64'(bus.dmem_bank_en_o), 64'(0));
    end
    chk("rand_stall", 64'(bus.stall_req_o), 64'((pend && starve >= LIMIT) || (dr && (pend || v))));
    chk("rand_idle", 64'(bus.idle_o), 64'(!pend && !v));
    if (pend) begin
      if (dy) begin
        void'(exp_q.pop_front());
        commits++;
        starve = 0;
        if (v) exp_q.push_back(bus.wbuf_entry_i);
      end else begin
        starve++;
      end
    end else if (v) begin
      exp_q.push_back(bus.wbuf_entry_i);
      starve = 0;
    end
  endtask

  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] bb_e[4];
    int            bb_bank[4];
    logic [63:0]   bb_d[4];
    logic [63:0]   sa_d;
    int            p_yumi;

    vecs[0] = '{5,  7, 2, 64'h1122_3344_5566_7788, 8'hFF, 8'h02, 9'd47};
    vecs[1] = '{63, 7, 7, 64'hA5A5_0F0F_DEAD_BEEF, 8'h5A, 8'h40, 9'd511};
    vecs[2] = '{0,  0, 0, 64'h0000_0000_0000_0001, 8'h00, 8'h01, 9'd0};
    vecs[3] = '{12, 6, 3, 64'hCAFE_F00D_1234_5678, 8'h0F, 8'h02, 9'd102};
    vecs[4] = '{33, 1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 8'h40, 9'd265};
    vecs[5] = '{20, 6, 4, 64'h0123_4567_89AB_CDEF, 8'h3C, 8'h04, 9'd166};

    bus.wbuf_v_i     = 1'b0;
    bus.wbuf_entry_i = '0;
    bus.dmem_yumi_i  = 1'b0;
    bus.drain_req_i  = 1'b0;

    // Reset state
    #12;
    chk("rst_dmem_v", 64'(bus.dmem_v_o), 64'(0));
    chk("rst_bank_en", 64'(bus.dmem_bank_en_o), 64'(0));
    chk("rst_data", bus.dmem_data_o, 64'(0));
    chk("rst_mask", 64'(bus.dmem_mask_o), 64'(0));
    chk("rst_stall", 64'(bus.stall_req_o), 64'(0));
    chk("rst_yumi", 64'(bus.wbuf_yumi_o), 64'(0));
    chk("rst_idle", 64'(bus.idle_o), 64'(1));
    #11 reset_n = 1'b1;

    // Directed vector table: single entry each, port always granted
    for (int i = 0; i < 6; i++) begin
      e = mk_entry(vecs[i].idx, vecs[i].off, vecs[i].way, vecs[i].data, vecs[i].mask);
      drive(1'b1, e, 1'b1, 1'b0);
      chk("vec_yumi", 64'(bus.wbuf_yumi_o), 64'(1));
      chk("vec_dmem_v_c0", 64'(bus.dmem_v_o), 64'(0));
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("vec_dmem_v_c1", 64'(bus.dmem_v_o), 64'(1));
      chk("vec_bank_en", 64'(bus.dmem_bank_en_o), 64'(vecs[i].exp_bank_en));
      chk("vec_addr", 64'(bus.dmem_addr_o), 64'(vecs[i].exp_addr));
      chk("vec_data", bus.dmem_data_o, vecs[i].data);
      chk("vec_mask", 64'(bus.dmem_mask_o), 64'(vecs[i].mask));
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("vec_idle_c2", 64'(bus.idle_o), 64'(1));
      chk("vec_dmem_v_c2", 64'(bus.dmem_v_o), 64'(0));
    end

    // Back-to-back: four entries, no bubble
    for (int k = 0; k < 4; k++) begin
      bb_d[k]    = {$urandom(), $urandom()};
      bb_e[k]    = mk_entry(k * 9 + 1, (k * 3) % 8, k + 4, bb_d[k], 8'(k * 17 + 1));
      bb_bank[k] = (k + 4 + (k * 3) % 8) % WAYS;
    end
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, (k < 4) ? bb_e[k] : '0, 1'b1, 1'b0);
      chk("b2b_yumi", 64'(bus.wbuf_yumi_o), 64'(k < 4));
      chk("b2b_dmem_v", 64'(bus.dmem_v_o), 64'(k > 0));
      if (k > 0) begin
        chk("b2b_data", bus.dmem_data_o, bb_d[k-1]);
        chk("b2b_bank_en", 64'(bus.dmem_bank_en_o), 64'(1 << bb_bank[k-1]));
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("b2b_idle", 64'(bus.idle_o), 64'(1));

    // Starvation: stall on the 5th ungranted pending cycle
    sa_d = 64'h5555_AAAA_1234_4321;
    drive(1'b1, mk_entry(3, 2, 1, sa_d, 8'hF0), 1'b0, 1'b0);
    chk("starve_accept", 64'(bus.wbuf_yumi_o), 64'(1));
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, mk_entry(4, 4, 4, 64'h9, 8'h01), 1'b0, 1'b0);
      chk("starve_stall", 64'(bus.stall_req_o), 64'(k >= 5));
      chk("starve_no_yumi", 64'(bus.wbuf_yumi_o), 64'(0));
      chk("starve_dmem_v", 64'(bus.dmem_v_o), 64'(1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("starve_grant_stall", 64'(bus.stall_req_o), 64'(1));
    chk("starve_grant_data", bus.dmem_data_o, sa_d);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("starve_after_stall", 64'(bus.stall_req_o), 64'(0));
    chk("starve_after_idle", 64'(bus.idle_o), 64'(1));

    // Drain request
    drive(1'b1, mk_entry(7, 5, 6, 64'h77, 8'h11), 1'b1, 1'b1);
    chk("drain_stall_empty", 64'(bus.stall_req_o), 64'(1));
    chk("drain_yumi", 64'(bus.wbuf_yumi_o), 64'(1));
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("drain_stall_pend", 64'(bus.stall_req_o), 64'(1));
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("drain_stall_idle", 64'(bus.stall_req_o), 64'(0));
    chk("drain_idle", 64'(bus.idle_o), 64'(1));

    // Asynchronous reset while a write is pending
    drive(1'b1, mk_entry(9, 3, 2, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("arst_pre_dmem_v", 64'(bus.dmem_v_o), 64'(1));
    chk("arst_pre_stall", 64'(bus.stall_req_o), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dmem_v", 64'(bus.dmem_v_o), 64'(0));
    chk("arst_stall", 64'(bus.stall_req_o), 64'(0));
    chk("arst_bank_en", 64'(bus.dmem_bank_en_o), 64'(0));
    chk("arst_data", bus.dmem_data_o, 64'(0));
    #1 reset_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("arst_idle", 64'(bus.idle_o), 64'(1));
    chk("arst_no_stale_c0", 64'(bus.dmem_v_o), 64'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("arst_no_stale_c1", 64'(bus.dmem_v_o), 64'(0));

    // Randomized traffic against the reference model
    exp_q.delete();
    starve = 0;
    p_yumi = 90;
    for (int c = 0; c < 900; c++) begin
      if (c % 60 == 0) begin
        case ($urandom_range(0, 2))
          0:       p_yumi = 95;
          1:       p_yumi = 50;
          default: p_yumi = 5;
        endcase
      end
      e = mk_entry(int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, WAYS - 1)),
                   int'($urandom_range(0, WAYS - 1)), {$urandom(), $urandom()}, 8'($urandom()));
      drive($urandom_range(0, 9) < 7, e, $urandom_range(0, 99) < p_yumi, $urandom_range(0, 9) == 0);
      model_cycle();
    end
    chk("rand_commits_seen", 64'(commits > 100), 64'(1));

    drive(1'b0, '0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
